// File: rtl/cache_mem_arbiter.sv
// rtl/cache_mem_arbiter.sv - two-master arbiter (icache m0, dcache m1) onto one memory bridge port
// Read and write channels arbitrate independently, each with its own round-robin pointer.
module cache_mem_arbiter #(
    parameter logic PRIO_INIT = 1'b0
) (
    input  logic         clk,
    input  logic         rst,

    input  logic         m0_rd_req,
    input  logic [2:0]   m0_rd_type,
    input  logic [31:0]  m0_rd_addr,
    output logic         m0_rd_rdy,
    output logic         m0_ret_valid,
    output logic         m0_ret_last,
    output logic [31:0]  m0_ret_data,
    input  logic         m0_wr_req,
    input  logic [2:0]   m0_wr_type,
    input  logic [31:0]  m0_wr_addr,
    input  logic [3:0]   m0_wr_wstrb,
    input  logic [127:0] m0_wr_data,
    output logic         m0_wr_rdy,

    input  logic         m1_rd_req,
    input  logic [2:0]   m1_rd_type,
    input  logic [31:0]  m1_rd_addr,
    output logic         m1_rd_rdy,
    output logic         m1_ret_valid,
    output logic         m1_ret_last,
    output logic [31:0]  m1_ret_data,
    input  logic         m1_wr_req,
    input  logic [2:0]   m1_wr_type,
    input  logic [31:0]  m1_wr_addr,
    input  logic [3:0]   m1_wr_wstrb,
    input  logic [127:0] m1_wr_data,
    output logic         m1_wr_rdy,

    output logic         mem_rd_req,
    output logic [2:0]   mem_rd_type,
    output logic [31:0]  mem_rd_addr,
    input  logic         mem_rd_rdy,
    input  logic         mem_ret_valid,
    input  logic         mem_ret_last,
    input  logic [31:0]  mem_ret_data,
    output logic         mem_wr_req,
    output logic [2:0]   mem_wr_type,
    output logic [31:0]  mem_wr_addr,
    output logic [3:0]   mem_wr_wstrb,
    output logic [127:0] mem_wr_data,
    input  logic         mem_wr_rdy
);

    typedef enum logic [1:0] {R_IDLE, R_REQ, R_RESP} rd_state_e;
    typedef enum logic       {W_IDLE, W_REQ}         wr_state_e;

    rd_state_e rd_state_q, rd_state_d;
    logic      rd_owner_q, rd_owner_d;
    logic      rd_ptr_q,   rd_ptr_d;
    wr_state_e wr_state_q, wr_state_d;
    logic      wr_owner_q, wr_owner_d;
    logic      wr_ptr_q,   wr_ptr_d;

    logic rd_owner_req;
    logic wr_owner_req;

    assign rd_owner_req = rd_owner_q ? m1_rd_req : m0_rd_req;
    assign wr_owner_req = wr_owner_q ? m1_wr_req : m0_wr_req;

    // With a single requester it wins outright; on contention the pointer decides.
    always_comb begin
        rd_state_d = rd_state_q;
        rd_owner_d = rd_owner_q;
        rd_ptr_d   = rd_ptr_q;
        case (rd_state_q)
            R_IDLE: begin
                if (m0_rd_req || m1_rd_req) begin
                    rd_owner_d = (m0_rd_req && m1_rd_req) ? rd_ptr_q : m1_rd_req;
                    rd_state_d = R_REQ;
                end
            end
            R_REQ: begin
                if (!rd_owner_req) begin
                    rd_state_d = R_IDLE;
                end else if (mem_rd_rdy) begin
                    rd_state_d = R_RESP;
                end
            end
            R_RESP: begin
                if (mem_ret_valid && mem_ret_last) begin
                    rd_state_d = R_IDLE;
                    rd_ptr_d   = ~rd_owner_q;
                end
            end
            default: rd_state_d = R_IDLE;
        endcase
    end

    always_comb begin
        wr_state_d = wr_state_q;
        wr_owner_d = wr_owner_q;
        wr_ptr_d   = wr_ptr_q;
        case (wr_state_q)
            W_IDLE: begin
                if (m0_wr_req || m1_wr_req) begin
                    wr_owner_d = (m0_wr_req && m1_wr_req) ? wr_ptr_q : m1_wr_req;
                    wr_state_d = W_REQ;
                end
            end
            W_REQ: begin
                if (!wr_owner_req) begin
                    wr_state_d = W_IDLE;
                end else if (mem_wr_rdy) begin
                    wr_state_d = W_IDLE;
                    wr_ptr_d   = ~wr_owner_q;
                end
            end
            default: wr_state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_state_q <= R_IDLE;
            rd_owner_q <= 1'b0;
            rd_ptr_q   <= PRIO_INIT;
            wr_state_q <= W_IDLE;
            wr_owner_q <= 1'b0;
            wr_ptr_q   <= PRIO_INIT;
        end else begin
            rd_state_q <= rd_state_d;
            rd_owner_q <= rd_owner_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_state_q <= wr_state_d;
            wr_owner_q <= wr_owner_d;
            wr_ptr_q   <= wr_ptr_d;
        end
    end

    logic rd_in_req, rd_in_resp, wr_in_req;
    assign rd_in_req  = (rd_state_q == R_REQ);
    assign rd_in_resp = (rd_state_q == R_RESP);
    assign wr_in_req  = (wr_state_q == W_REQ);

    assign mem_rd_req  = rd_in_req & rd_owner_req;
    assign mem_rd_type = rd_owner_q ? m1_rd_type : m0_rd_type;
    assign mem_rd_addr = rd_owner_q ? m1_rd_addr : m0_rd_addr;

    assign m0_rd_rdy = rd_in_req & ~rd_owner_q & mem_rd_rdy;
    assign m1_rd_rdy = rd_in_req &  rd_owner_q & mem_rd_rdy;

    // Return beats outside R_RESP belong to no one and are dropped here.
    assign m0_ret_valid = rd_in_resp & ~rd_owner_q & mem_ret_valid;
    assign m1_ret_valid = rd_in_resp &  rd_owner_q & mem_ret_valid;
    assign m0_ret_last  = rd_in_resp & ~rd_owner_q & mem_ret_last;
    assign m1_ret_last  = rd_in_resp &  rd_owner_q & mem_ret_last;
    assign m0_ret_data  = mem_ret_data;
    assign m1_ret_data  = mem_ret_data;

    assign mem_wr_req   = wr_in_req & wr_owner_req;
    assign mem_wr_type  = wr_owner_q ? m1_wr_type  : m0_wr_type;
    assign mem_wr_addr  = wr_owner_q ? m1_wr_addr  : m0_wr_addr;
    assign mem_wr_wstrb = wr_owner_q ? m1_wr_wstrb : m0_wr_wstrb;
    assign mem_wr_data  = wr_owner_q ? m1_wr_data  : m0_wr_data;

    assign m0_wr_rdy = wr_in_req & ~wr_owner_q & mem_wr_rdy;
    assign m1_wr_rdy = wr_in_req &  wr_owner_q & mem_wr_rdy;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// tb/tb_cache_mem_arbiter.sv - randomized self-checking bench for cache_mem_arbiter
// Master/memory stimulus is checked against a transaction-level round-robin model.
module tb_cache_mem_arbiter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [1:0]   rd_req;
    logic [2:0]   rd_type [2];
    logic [31:0]  rd_addr [2];
    logic [1:0]   rd_rdy, ret_valid, ret_last;
    logic [31:0]  ret_data [2];
    logic [1:0]   wr_req, wr_rdy;
    logic [2:0]   wr_type [2];
    logic [31:0]  wr_addr [2];
    logic [3:0]   wr_wstrb [2];
    logic [127:0] wr_data [2];

    logic         mem_rd_req, mem_rd_rdy, mem_ret_valid, mem_ret_last;
    logic [2:0]   mem_rd_type;
    logic [31:0]  mem_rd_addr, mem_ret_data;
    logic         mem_wr_req, mem_wr_rdy;
    logic [2:0]   mem_wr_type;
    logic [31:0]  mem_wr_addr;
    logic [3:0]   mem_wr_wstrb;
    logic [127:0] mem_wr_data;

    cache_mem_arbiter dut (
        .clk(clk), .rst(rst),
        .m0_rd_req(rd_req[0]), .m0_rd_type(rd_type[0]), .m0_rd_addr(rd_addr[0]), .m0_rd_rdy(rd_rdy[0]),
        .m0_ret_valid(ret_valid[0]), .m0_ret_last(ret_last[0]), .m0_ret_data(ret_data[0]),
        .m0_wr_req(wr_req[0]), .m0_wr_type(wr_type[0]), .m0_wr_addr(wr_addr[0]),
        .m0_wr_wstrb(wr_wstrb[0]), .m0_wr_data(wr_data[0]), .m0_wr_rdy(wr_rdy[0]),
        .m1_rd_req(rd_req[1]), .m1_rd_type(rd_type[1]), .m1_rd_addr(rd_addr[1]), .m1_rd_rdy(rd_rdy[1]),
        .m1_ret_valid(ret_valid[1]), .m1_ret_last(ret_last[1]), .m1_ret_data(ret_data[1]),
        .m1_wr_req(wr_req[1]), .m1_wr_type(wr_type[1]), .m1_wr_addr(wr_addr[1]),
        .m1_wr_wstrb(wr_wstrb[1]), .m1_wr_data(wr_data[1]), .m1_wr_rdy(wr_rdy[1]),
        .mem_rd_req(mem_rd_req), .mem_rd_type(mem_rd_type), .mem_rd_addr(mem_rd_addr),
        .mem_rd_rdy(mem_rd_rdy), .mem_ret_valid(mem_ret_valid), .mem_ret_last(mem_ret_last),
        .mem_ret_data(mem_ret_data),
        .mem_wr_req(mem_wr_req), .mem_wr_type(mem_wr_type), .mem_wr_addr(mem_wr_addr),
        .mem_wr_wstrb(mem_wr_wstrb), .mem_wr_data(mem_wr_data), .mem_wr_rdy(mem_wr_rdy)
    );

    int checks = 0;
    int passes = 0;
    int rd_ptr_m = 0;
    int wr_ptr_m = 0;

    // mode: 0 random requesters, 1 only m1, 2 both in the first round
    task automatic test_reads(input int n, input int mode, input int stall, input int beats);
        int r, w, k, nb;
        bit go;
        bit last;
        logic [31:0] d;
        r = 0;
        while (r < n || rd_req != 2'b00) begin
            mem_ret_valid = 1'b0; mem_ret_last = 1'b0; mem_rd_rdy = 1'b0;
            for (int i = 0; i < 2; i++) begin
                if (!rd_req[i] && r < n) begin
                    go = (mode == 1) ? (i == 1) : (mode == 2 && r == 0) ? 1'b1 : 1'($urandom_range(0, 1));
                    if (go) begin
                        rd_req[i] = 1'b1; rd_addr[i] = $urandom; rd_type[i] = 3'($urandom_range(0, 7));
                    end
                end
            end
            if (rd_req == 2'b00) begin
                rd_req[1] = 1'b1; rd_addr[1] = $urandom; rd_type[1] = 3'($urandom_range(0, 7));
            end
            r++;
            w = (rd_req == 2'b11) ? rd_ptr_m : (rd_req[0] ? 0 : 1);
            #1;
            checks++;
            if ({mem_rd_req, rd_rdy, ret_valid} !== 5'b0)
                $display("FAIL rd_idle: req=%b rdy=%b ret_valid=%b, want all 0", mem_rd_req, rd_rdy, ret_valid);
            else passes++;
            @(negedge clk); #1;
            checks++;
            if ({mem_rd_req, mem_rd_addr, mem_rd_type} !== {1'b1, rd_addr[w], rd_type[w]})
                $display("FAIL rd_grant: req=%b addr=%h type=%0d, want 1 %h %0d (m%0d)",
                         mem_rd_req, mem_rd_addr, mem_rd_type, rd_addr[w], rd_type[w], w);
            else passes++;
            k = (stall >= 0) ? stall : $urandom_range(0, 3);
            for (int c = 0; c <= k; c++) begin
                if (c > 0) @(negedge clk);
                mem_rd_rdy = (c == k);
                #1;
                checks++;
                if ({mem_rd_req, mem_rd_addr, rd_rdy[w], rd_rdy[1-w]} !== {1'b1, rd_addr[w], mem_rd_rdy, 1'b0})
                    $display("FAIL rd_rdy: req=%b addr=%h rdy=%b, want 1 %h owner m%0d rdy=%b",
                             mem_rd_req, mem_rd_addr, rd_rdy, rd_addr[w], w, mem_rd_rdy);
                else passes++;
            end
            @(negedge clk);
            mem_rd_rdy = 1'b0;
            rd_req[w] = 1'b0;
            nb = (beats > 0) ? beats : $urandom_range(1, 4);
            for (int b = 0; b < nb; b++) begin
                if ($urandom_range(0, 2) == 0) begin
                    mem_ret_valid = 1'b0; mem_ret_last = 1'b0;
                    #1;
                    checks++;
                    if ({ret_valid, ret_last, mem_rd_req} !== 5'b0)
                        $display("FAIL rd_gap: ret_valid=%b ret_last=%b req=%b, want 0", ret_valid, ret_last, mem_rd_req);
                    else passes++;
                    @(negedge clk);
                end
                last = (b == nb - 1);
                d = $urandom;
                mem_ret_valid = 1'b1; mem_ret_last = last; mem_ret_data = d;
                #1;
                checks++;
                if ({ret_valid[w], ret_valid[1-w], ret_last[w], ret_last[1-w], ret_data[0], ret_data[1], mem_rd_req}
                    !== {1'b1, 1'b0, last, 1'b0, d, d, 1'b0})
                    $display("FAIL rd_beat: valid=%b last=%b data=%h/%h, want owner m%0d last=%b data=%h",
                             ret_valid, ret_last, ret_data[0], ret_data[1], w, last, d);
                else passes++;
                @(negedge clk);
            end
            rd_ptr_m = 1 - w;
        end
        mem_ret_valid = 1'b0; mem_ret_last = 1'b0;
    endtask

    task automatic test_writes(input int n, input int mode, input int stall);
        int r, w, k;
        bit go;
        r = 0;
        while (r < n || wr_req != 2'b00) begin
            mem_wr_rdy = 1'b0;
            for (int i = 0; i < 2; i++) begin
                if (!wr_req[i] && r < n) begin
                    go = (mode == 2 && r == 0) ? 1'b1 : 1'($urandom_range(0, 1));
                    if (go) begin
                        wr_req[i] = 1'b1; wr_addr[i] = $urandom; wr_type[i] = 3'($urandom_range(0, 7));
                        wr_wstrb[i] = 4'($urandom); wr_data[i] = {$urandom, $urandom, $urandom, $urandom};
                    end
                end
            end
            if (wr_req == 2'b00) begin
                wr_req[0] = 1'b1; wr_addr[0] = $urandom; wr_type[0] = 3'd1;
                wr_wstrb[0] = 4'hf; wr_data[0] = {$urandom, $urandom, $urandom, $urandom};
            end
            r++;
            w = (wr_req == 2'b11) ? wr_ptr_m : (wr_req[0] ? 0 : 1);
            #1;
            checks++;
            if ({mem_wr_req, wr_rdy} !== 3'b0)
                $display("FAIL wr_idle: req=%b rdy=%b, want 0", mem_wr_req, wr_rdy);
            else passes++;
            @(negedge clk);
            k = (stall >= 0) ? stall : $urandom_range(0, 3);
            for (int c = 0; c <= k; c++) begin
                if (c > 0) @(negedge clk);
                mem_wr_rdy = (c == k);
                #1;
                checks++;
                if ({mem_wr_req, mem_wr_addr, mem_wr_type, mem_wr_wstrb, mem_wr_data, wr_rdy[w], wr_rdy[1-w]}
                    !== {1'b1, wr_addr[w], wr_type[w], wr_wstrb[w], wr_data[w], mem_wr_rdy, 1'b0})
                    $display("FAIL wr_grant: req=%b addr=%h data=%h rdy=%b, want owner m%0d addr=%h data=%h",
                             mem_wr_req, mem_wr_addr, mem_wr_data, wr_rdy, w, wr_addr[w], wr_data[w]);
                else passes++;
            end
            @(negedge clk);
            mem_wr_rdy = 1'b0;
            wr_req[w] = 1'b0;
            wr_ptr_m = 1 - w;
        end
    endtask

    task automatic test_reset;
        rd_addr[0] = 32'h1111_0000; rd_addr[1] = 32'h2222_0000;
        wr_addr[0] = 32'h3333_0000; wr_addr[1] = 32'h4444_0000;
        #1;
        checks++;
        if ({mem_rd_req, mem_wr_req, rd_rdy, wr_rdy, ret_valid, ret_last} !== 10'b0)
            $display("FAIL reset_outputs: rdreq=%b wrreq=%b rdy=%b/%b ret=%b/%b, want 0",
                     mem_rd_req, mem_wr_req, rd_rdy, wr_rdy, ret_valid, ret_last);
        else passes++;
        checks++;
        if ({mem_rd_addr, mem_wr_addr} !== {32'h1111_0000, 32'h3333_0000})
            $display("FAIL reset_owner: rd_addr=%h wr_addr=%h, want m0 fields", mem_rd_addr, mem_wr_addr);
        else passes++;
    endtask

    task automatic test_concurrent;
        logic [31:0] d;
        wr_req[1] = 1'b1; wr_addr[1] = 32'h1000_0040; wr_type[1] = 3'd2;
        wr_wstrb[1] = 4'hf; wr_data[1] = {$urandom, $urandom, $urandom, $urandom};
        rd_req[0] = 1'b1; rd_addr[0] = 32'h0000_2000; rd_type[0] = 3'd4;
        @(negedge clk); #1;
        checks++;
        if ({mem_rd_req, mem_wr_req, mem_rd_addr, mem_wr_addr} !== {2'b11, 32'h0000_2000, 32'h1000_0040})
            $display("FAIL concurrent_grant: rd=%b wr=%b rd_addr=%h wr_addr=%h, want both 1",
                     mem_rd_req, mem_wr_req, mem_rd_addr, mem_wr_addr);
        else passes++;
        mem_rd_rdy = 1'b1; mem_wr_rdy = 1'b1;
        #1;
        checks++;
        if ({rd_rdy, wr_rdy} !== 4'b01_10)
            $display("FAIL concurrent_rdy: rd_rdy=%b wr_rdy=%b, want 01 10", rd_rdy, wr_rdy);
        else passes++;
        @(negedge clk);
        mem_rd_rdy = 1'b0; mem_wr_rdy = 1'b0; rd_req[0] = 1'b0; wr_req[1] = 1'b0;
        wr_ptr_m = 0;
        d = $urandom;
        mem_ret_valid = 1'b1; mem_ret_last = 1'b1; mem_ret_data = d;
        #1;
        checks++;
        if ({ret_valid, ret_last, ret_data[0], mem_wr_req} !== {4'b01_01, d, 1'b0})
            $display("FAIL concurrent_ret: valid=%b last=%b data=%h wr_req=%b, want m0 beat %h",
                     ret_valid, ret_last, ret_data[0], mem_wr_req, d);
        else passes++;
        @(negedge clk);
        mem_ret_valid = 1'b0; mem_ret_last = 1'b0;
        rd_ptr_m = 1;
    endtask

    task automatic test_stray;
        for (int c = 0; c < 3; c++) begin
            mem_ret_valid = 1'b1; mem_ret_last = 1'($urandom_range(0, 1)); mem_ret_data = $urandom;
            #1;
            checks++;
            if ({ret_valid, ret_last, mem_rd_req} !== 5'b0)
                $display("FAIL stray_beat: valid=%b last=%b req=%b, want 0", ret_valid, ret_last, mem_rd_req);
            else passes++;
            @(negedge clk);
        end
        mem_ret_valid = 1'b0; mem_ret_last = 1'b0;
        test_reads(4, 2, -1, 0);
    endtask

    task automatic test_reset_mid_read;
        rd_req = 2'b01; rd_addr[0] = 32'h0000_3000; rd_type[0] = 3'd0;
        @(negedge clk);
        mem_rd_rdy = 1'b1;
        @(negedge clk);
        mem_rd_rdy = 1'b0; rd_req = 2'b00;
        for (int b = 0; b < 2; b++) begin
            mem_ret_valid = 1'b1; mem_ret_last = 1'b0; mem_ret_data = $urandom;
            #1;
            checks++;
            if (ret_valid !== 2'b01)
                $display("FAIL rst_pre_beat: valid=%b, want 01", ret_valid);
            else passes++;
            @(negedge clk);
        end
        rst = 1'b1; mem_ret_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int b = 2; b < 4; b++) begin
            mem_ret_valid = 1'b1; mem_ret_last = (b == 3); mem_ret_data = $urandom;
            #1;
            checks++;
            if ({mem_rd_req, mem_wr_req, rd_rdy, wr_rdy, ret_valid, ret_last} !== 10'b0)
                $display("FAIL rst_post_beat%0d: rdreq=%b wrreq=%b rdy=%b/%b ret=%b/%b, want 0",
                         b, mem_rd_req, mem_wr_req, rd_rdy, wr_rdy, ret_valid, ret_last);
            else passes++;
            @(negedge clk);
        end
        mem_ret_valid = 1'b0; mem_ret_last = 1'b0;
        rd_ptr_m = 0; wr_ptr_m = 0;
        test_reads(2, 2, -1, 0);
        test_writes(2, 2, -1);
    endtask

    initial begin
        rst = 1'b1;
        rd_req = 2'b00; wr_req = 2'b00;
        for (int i = 0; i < 2; i++) begin
            rd_type[i] = 3'd0; rd_addr[i] = 32'd0;
            wr_type[i] = 3'd0; wr_addr[i] = 32'd0; wr_wstrb[i] = 4'd0; wr_data[i] = 128'd0;
        end
        mem_rd_rdy = 1'b0; mem_ret_valid = 1'b0; mem_ret_last = 1'b0; mem_ret_data = 32'd0;
        mem_wr_rdy = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        test_reset();
        test_reads(1, 2, 0, 4);
        test_reads(3, 1, -1, 0);
        test_writes(1, 2, 5);
        test_writes(8, 0, -1);
        test_concurrent();
        test_stray();
        test_reads(25, 0, -1, 0);
        test_reset_mid_read();
        test_writes(12, 0, -1);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
